node_processing_mem_stream_reader: RTL

- Avalon-MM master that drives the 16-bit second port (s2) of a node's dual-port processing memory.
- On a command, it reads a block of halfwords, optionally wrapping at the end of memory.
- It emits the halfwords as an Avalon-ST packet with backpressure, then writes a completion status halfword back into memory.
- It sits beside the Nios core, which uses the 32-bit port, and offloads outbound message transfer from the node.

---
 rtl/node_mem_pkg.sv | 25 ++
 rtl/node_mem_read_fifo.sv | 55 +++++
 rtl/node_processing_mem_stream_reader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/node_mem_pkg.sv
// Shared definitions for the node processing-memory stream reader.
//   MEM_WORDS   : depth of the 16-bit s2 view in halfwords (addresses wrap to 0)
//   ADDR_W      : width of s2 addresses, lengths and counters
//   STATUS_FLAG : ORed with the transferred length in the completion status word
//   state_t     : reader FSM states
//   next_addr() : increment an s2 address with wrap at MEM_WORDS-1
package node_mem_pkg;

  localparam int          MEM_WORDS   = 10000;
  localparam int          ADDR_W      = 14;
  localparam logic [15:0] STATUS_FLAG = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WBACK
  } state_t;

  // The memory is not a power of two deep, so wrap on an explicit compare
  // rather than letting the counter roll over at 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(MEM_WORDS - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/node_mem_read_fifo.sv
// Read-return buffer between the s2 read port and the Avalon-ST output.
//   clk, reset : clock and synchronous active-high reset (flushes the buffer)
//   push       : store push_data this cycle
//   push_data  : halfword returned by the memory
//   pop        : drop the head entry this cycle
//   count      : number of valid entries (0..DEPTH)
//   head       : oldest entry; only meaningful while count != 0
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// The caller never pushes when full or pops when empty.
module node_mem_read_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + ($clog2(DEPTH) + 1)'(1);
        2'b01:   count <= count - ($clog2(DEPTH) + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the data array is deliberately not reset; the pointers and count
  // define which entries are valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) storage[wr_ptr] <= push_data;
  end

  assign head = storage[rd_ptr];

endmodule

// File: rtl/node_processing_mem_stream_reader.sv
// Avalon-MM master on the 16-bit s2 port of a node's processing memory.
// Reads a block of halfwords (wrapping at the end of memory), streams them out
// as one Avalon-ST packet with backpressure, then writes a status halfword
// (STATUS_FLAG | len) to a caller-chosen address.
//   clk, reset        : clock, synchronous active-high reset
//   cmd_*             : command handshake; cmd_ready is high only in IDLE
//   mem_*             : s2 Avalon-MM master; read data returns one cycle after issue
//   st_*              : Avalon-ST source, ready latency 0, sop/eop framing
//   busy              : high whenever not in IDLE
//   done              : one-cycle pulse on the cycle the status write is issued
// FIFO_DEPTH must be a power of two and at least 2.
module node_processing_mem_stream_reader
  import node_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [ADDR_W-1:0] cmd_status_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [15:0]       mem_writedata,
  output logic [1:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [15:0]       mem_readdata,
  output logic [15:0]       st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] status_addr_q;
  logic [ADDR_W-1:0] remaining_issue;
  logic [ADDR_W-1:0] remaining_out;
  logic              inflight;

  logic [CNT_W-1:0]  fifo_count;
  logic [15:0]       fifo_head;
  logic [CNT_W:0]    occupancy;
  logic              in_read;
  logic              issue;
  logic              pop;

  assign in_read = (state == READ);

  // Entries held plus the read still returning must never exceed the buffer,
  // so a returning read always has somewhere to land without a stall.
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
  assign issue     = in_read && (remaining_issue != '0)
                     && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

  assign st_valid = in_read && (fifo_count != '0);
  assign pop      = st_valid && st_ready;

  node_mem_read_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data (mem_readdata),
    .pop       (pop),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cur_addr        <= '0;
      len_q           <= '0;
      status_addr_q   <= '0;
      remaining_issue <= '0;
      remaining_out   <= '0;
      inflight        <= 1'b0;
    end else begin
      // A read issued now returns next cycle; this flag turns it into a push.
      inflight <= issue;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cur_addr        <= cmd_addr;
            len_q           <= cmd_len;
            status_addr_q   <= cmd_status_addr;
            remaining_issue <= cmd_len;
            remaining_out   <= cmd_len;
            state           <= (cmd_len == '0) ? WBACK : READ;
          end
        end
        READ: begin
          if (issue) begin
            cur_addr        <= next_addr(cur_addr);
            remaining_issue <= remaining_issue - ADDR_W'(1);
          end
          if (pop) begin
            remaining_out <= remaining_out - ADDR_W'(1);
            // All reads have been issued and returned by the last pop.
            if (remaining_out == ADDR_W'(1)) state <= WBACK;
          end
        end
        WBACK:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; none depends on a same-cycle input,
  // and everything not actively driving a transfer sits at 0.
  assign cmd_ready      = (state == IDLE);
  assign busy           = (state != IDLE);
  assign done           = (state == WBACK);

  assign mem_chipselect = issue || done;
  assign mem_write      = done;
  assign mem_address    = issue ? cur_addr : (done ? status_addr_q : '0);
  assign mem_writedata  = done ? (STATUS_FLAG | 16'(len_q)) : '0;
  assign mem_byteenable = 2'b11;
  assign mem_clken      = 1'b1;

  assign st_data        = st_valid ? fifo_head : '0;
  assign st_sop         = st_valid && (remaining_out == len_q);
  assign st_eop         = st_valid && (remaining_out == ADDR_W'(1));

endmodule
